// File: rtl/au_sched.sv
// ---------------------------------------------------------------------------
// au_sched -- shares one W-bit arithmetic unit (add, sub, mul, div with
// remainder) between two requesters. A round-robin arbiter in IDLE picks one
// request. Add/sub/mul finish at the acceptance edge. Divide runs as a
// restoring divider that produces one quotient bit per edge. One response
// at a time is returned on a valid/ready channel, tagged with the requester ID.
//
// Handshake rule, both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. A requester must hold its operands
// and op stable while valid=1 and ready=0. The response channel holds rsp_*
// stable while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/op      requester N (N=0,1) operation channel
//   rsp_valid/ready              response channel handshake
//   rsp_id, rsp_op               issuing requester and op code
//   rsp_res, rsp_rem             result and remainder (2*W bits)
//   busy                         high whenever the FSM is not in IDLE
//   state_dbg                    current FSM state (IDLE=0, DIV=1, RESP=2)
//
// Optional build macro AU_SCHED_STATS_EN adds these outputs:
//   stat_cnt0, stat_cnt1 (16b)   completed responses per requester, wrapping
//   stat_dz (8b)                 saturating count of divide-by-zero ops
// ---------------------------------------------------------------------------
module au_sched #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [W-1:0]     req0_a,
   input  logic [W-1:0]     req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [W-1:0]     req1_a,
   input  logic [W-1:0]     req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [1:0]       rsp_op,
   output logic [2*W-1:0]   rsp_res,
   output logic [2*W-1:0]   rsp_rem,
   output logic             busy,
   output logic [1:0]       state_dbg
`ifdef AU_SCHED_STATS_EN
   ,
   output logic [15:0]      stat_cnt0,
   output logic [15:0]      stat_cnt1,
   output logic [7:0]       stat_dz
`endif
);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;
   localparam int         CW     = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            ptr;
   logic            any_valid, grant, accept;
   logic [W-1:0]    sel_a, sel_b;
   logic [1:0]      sel_op;

   logic [W-1:0]    div_q, div_dvs, div_rem;
   logic            div_dz;
   logic [CW-1:0]   div_cnt;

   logic [W-1:0]    s_q, s_dvs, s_rem;
   logic [W:0]      trial, diff;
   logic            step_ge;
   logic [W-1:0]    step_q, step_rem;

   // Arbitration: one valid requester wins outright; when both are valid the
   // pointer decides. Ready is forced low while reset is asserted.
   assign any_valid  = req0_valid | req1_valid;
   assign grant      = (req0_valid & req1_valid) ? ptr : req1_valid;
   assign req0_ready = (state == IDLE) & ~rst & any_valid & ~grant;
   assign req1_ready = (state == IDLE) & ~rst & any_valid & grant;
   assign accept     = req0_ready | req1_ready;

   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;
   assign sel_op = grant ? req1_op : req0_op;

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // One restoring-division step. The first iteration is folded into the
   // acceptance edge: in IDLE the step is fed straight from the incoming
   // operands with a zero partial remainder. That way the quotient is
   // complete W edges after acceptance, not W+1.
   always_comb begin
      s_q   = div_q;
      s_dvs = div_dvs;
      s_rem = div_rem;
      if (state == IDLE) begin
         s_q   = sel_a;
         s_dvs = sel_b;
         s_rem = '0;
      end
      trial    = {s_rem, s_q[W-1]};
      diff     = trial - {1'b0, s_dvs};
      step_ge  = (trial >= {1'b0, s_dvs});
      step_rem = step_ge ? diff[W-1:0] : trial[W-1:0];
      step_q   = {s_q[W-2:0], step_ge};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (sel_op == OP_DIV) ? DIV : RESP;
         DIV:     if (div_cnt == CNT_ONE) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= 1'b0;
         rsp_id  <= 1'b0;
         rsp_op  <= 2'd0;
         rsp_res <= '0;
         rsp_rem <= '0;
         div_q   <= '0;
         div_dvs <= '0;
         div_rem <= '0;
         div_dz  <= 1'b0;
         div_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ptr    <= ~grant;
                  rsp_id <= grant;
                  rsp_op <= sel_op;
                  case (sel_op)
                     OP_ADD: begin
                        rsp_res <= {{W{1'b0}}, sel_a} + {{W{1'b0}}, sel_b};
                        rsp_rem <= '0;
                     end
                     OP_SUB: begin
                        rsp_res <= {{W{1'b0}}, sel_a} - {{W{1'b0}}, sel_b};
                        rsp_rem <= '0;
                     end
                     OP_MUL: begin
                        rsp_res <= {{W{1'b0}}, sel_a} * {{W{1'b0}}, sel_b};
                        rsp_rem <= '0;
                     end
                     default: begin
                        div_q   <= step_q;
                        div_rem <= step_rem;
                        div_dvs <= sel_b;
                        div_dz  <= (sel_b == '0);
                        div_cnt <= CW'(W - 1);
                     end
                  endcase
               end
            end
            DIV: begin
               div_q   <= step_q;
               div_rem <= step_rem;
               div_cnt <= div_cnt - CNT_ONE;
               if (div_cnt == CNT_ONE) begin
                  // A zero divisor makes every trial subtraction succeed,
                  // so the remainder ends up equal to the dividend. Only the
                  // quotient needs overriding, to all ones across 2*W bits.
                  rsp_res <= div_dz ? {2*W{1'b1}} : {{W{1'b0}}, step_q};
                  rsp_rem <= {{W{1'b0}}, step_rem};
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AU_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_cnt0 <= '0;
         stat_cnt1 <= '0;
         stat_dz   <= '0;
      end else begin
         if ((state == RESP) && rsp_ready) begin
            if (rsp_id) stat_cnt1 <= stat_cnt1 + 16'd1;
            else        stat_cnt0 <= stat_cnt0 + 16'd1;
         end
         if (accept && (sel_op == OP_DIV) && (sel_b == '0) && (stat_dz != 8'hFF))
            stat_dz <= stat_dz + 8'd1;
      end
   end
`endif

endmodule
